judge_arbiter: RTL and testbench

Shares the single score datapath between the four lane judges. Each lane raises a hit or miss event through a req/ack handshake. A round-robin arbiter accepts at most one event per `Clk` cycle and counts it into per-lane hit/miss accumulators. On each `frame_clk` rising edge the accumulators are published as the frame's `hit0..3` / `miss0..3` vectors that feed the score register. The block also tracks the current and maximum combo for the HUD.

---
 rtl/judge_arbiter_if.sv | 23 ++
 rtl/judge_arbiter.sv | 106 ++++++++++
 tb/tb_judge_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/judge_arbiter_if.sv
// Lane event handshake and published frame counts between the lane judges and the score datapath.
interface judge_arbiter_if #(
  parameter int CNT_W   = 4,
  parameter int COMBO_W = 8
);
  logic [3:0]         lane_req;
  logic [3:0]         lane_miss;
  logic [3:0]         lane_ack;
  logic [CNT_W-1:0]   hit0, hit1, hit2, hit3;
  logic [CNT_W-1:0]   miss0, miss1, miss2, miss3;
  logic [COMBO_W-1:0] combo;
  logic [COMBO_W-1:0] max_combo;

  modport master (
    output lane_req, lane_miss,
    input  lane_ack, hit0, hit1, hit2, hit3, miss0, miss1, miss2, miss3, combo, max_combo
  );

  modport slave (
    input  lane_req, lane_miss,
    output lane_ack, hit0, hit1, hit2, hit3, miss0, miss1, miss2, miss3, combo, max_combo
  );
endinterface

// File: rtl/judge_arbiter.sv
// Round-robin arbiter that folds lane hit/miss events into per-frame counts and tracks combo.
module judge_arbiter #(
  parameter int CNT_W   = 4,
  parameter int COMBO_W = 8
) (
  input  logic           Clk,
  input  logic           reset,
  input  logic           frame_clk,
  judge_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

  logic [3:0]         ack_q;
  logic [3:0]         elig;
  logic [3:0]         hit_evt;
  logic [3:0]         miss_evt;
  logic [1:0]         rr;
  logic [1:0]         grant_idx;
  logic [1:0]         cand;
  logic               grant_vld;
  logic               grant_hit;
  logic               frame_clk_d;
  logic               frame_edge;
  logic [CNT_W-1:0]   acc_hit  [4];
  logic [CNT_W-1:0]   acc_miss [4];
  logic [CNT_W-1:0]   pub_hit  [4];
  logic [CNT_W-1:0]   pub_miss [4];
  logic [COMBO_W-1:0] combo_q;
  logic [COMBO_W-1:0] max_q;
  logic [COMBO_W-1:0] combo_inc;

  // A request still high during its own ack cycle must not win again.
  assign elig       = bus.lane_req & ~ack_q;
  assign frame_edge = frame_clk & ~frame_clk_d;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr;
    cand      = rr;
    for (int i = 0; i < 4; i++) begin
      cand = rr + 2'(i);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_hit = grant_vld & ~bus.lane_miss[grant_idx];
  assign hit_evt   = grant_hit ? (4'b0001 << grant_idx) : 4'b0000;
  assign miss_evt  = (grant_vld && !grant_hit) ? (4'b0001 << grant_idx) : 4'b0000;
  assign combo_inc = (combo_q == COMBO_MAX) ? combo_q : combo_q + 1'b1;

  always_ff @(posedge Clk) begin
    if (reset) begin
      ack_q       <= '0;
      rr          <= '0;
      frame_clk_d <= 1'b0;
      combo_q     <= '0;
      max_q       <= '0;
      for (int k = 0; k < 4; k++) begin
        acc_hit[k]  <= '0;
        acc_miss[k] <= '0;
        pub_hit[k]  <= '0;
        pub_miss[k] <= '0;
      end
    end else begin
      ack_q       <= grant_vld ? (4'b0001 << grant_idx) : 4'b0000;
      frame_clk_d <= frame_clk;
      if (grant_vld) begin
        rr <= grant_idx + 2'd1;
        if (grant_hit) begin
          combo_q <= combo_inc;
          if (combo_inc > max_q) max_q <= combo_inc;
        end else begin
          combo_q <= '0;
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (frame_edge) begin
          // Publish the closed frame; an event granted now opens the new one.
          pub_hit[k]  <= acc_hit[k];
          pub_miss[k] <= acc_miss[k];
          acc_hit[k]  <= CNT_W'(hit_evt[k]);
          acc_miss[k] <= CNT_W'(miss_evt[k]);
        end else begin
          if (hit_evt[k] && acc_hit[k] != CNT_MAX)   acc_hit[k]  <= acc_hit[k] + 1'b1;
          if (miss_evt[k] && acc_miss[k] != CNT_MAX) acc_miss[k] <= acc_miss[k] + 1'b1;
        end
      end
    end
  end

  assign bus.lane_ack  = ack_q;
  assign bus.hit0      = pub_hit[0];
  assign bus.hit1      = pub_hit[1];
  assign bus.hit2      = pub_hit[2];
  assign bus.hit3      = pub_hit[3];
  assign bus.miss0     = pub_miss[0];
  assign bus.miss1     = pub_miss[1];
  assign bus.miss2     = pub_miss[2];
  assign bus.miss3     = pub_miss[3];
  assign bus.combo     = combo_q;
  assign bus.max_combo = max_q;
endmodule

// File: tb/tb_judge_arbiter.sv
// Directed bench for judge_arbiter: event-queue requesters, a frame-level scoreboard and literal checkpoints.
module tb_judge_arbiter;
  logic Clk = 1'b0;
  logic reset = 1'b1;
  logic frame_clk = 1'b0;

  judge_arbiter_if #(.CNT_W(4), .COMBO_W(8)) bus ();

  judge_arbiter #(.CNT_W(4), .COMBO_W(8)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pending events per lane (1 = miss); the head is what the lane presents.
  bit evq [4][$];

  always @(negedge Clk) begin
    for (int k = 0; k < 4; k++) begin
      if (bus.lane_ack[k] === 1'b1 && evq[k].size() > 0) void'(evq[k].pop_front());
      if (evq[k].size() > 0) begin
        bus.lane_req[k]  = 1'b1;
        bus.lane_miss[k] = evq[k][0];
      end else begin
        bus.lane_req[k]  = 1'b0;
        bus.lane_miss[k] = 1'b0;
      end
    end
  end

  // Scoreboard: frame-level view of what the outputs must be.
  int m_rr = 0;
  int m_ack = -1;
  bit m_fd = 1'b0;
  int m_acc_hit [4];
  int m_acc_miss [4];
  int m_pub_hit [4];
  int m_pub_miss [4];
  int m_combo = 0;
  int m_max = 0;

  always @(posedge Clk) begin
    int g;
    int k;
    bit fe;
    if (reset) begin
      m_rr = 0; m_ack = -1; m_fd = 1'b0; m_combo = 0; m_max = 0;
      for (int i = 0; i < 4; i++) begin
        m_acc_hit[i] = 0; m_acc_miss[i] = 0; m_pub_hit[i] = 0; m_pub_miss[i] = 0;
      end
    end else begin
      g = -1;
      for (int i = 0; i < 4; i++) begin
        k = (m_rr + i) % 4;
        if (g < 0 && bus.lane_req[k] === 1'b1 && m_ack != k) g = k;
      end
      fe = frame_clk && !m_fd;
      m_fd = frame_clk;
      if (fe) begin
        for (int i = 0; i < 4; i++) begin
          m_pub_hit[i] = m_acc_hit[i]; m_pub_miss[i] = m_acc_miss[i];
          m_acc_hit[i] = 0; m_acc_miss[i] = 0;
        end
      end
      if (g >= 0) begin
        m_rr = (g + 1) % 4;
        if (bus.lane_miss[g] === 1'b1) begin
          if (m_acc_miss[g] < 15) m_acc_miss[g]++;
          m_combo = 0;
        end else begin
          if (m_acc_hit[g] < 15) m_acc_hit[g]++;
          if (m_combo < 255) m_combo++;
          if (m_combo > m_max) m_max = m_combo;
        end
      end
      m_ack = g;
    end
  end

  int ack_cnt [4];

  always @(posedge Clk) begin
    #3;
    for (int i = 0; i < 4; i++) if (bus.lane_ack[i] === 1'b1) ack_cnt[i]++;
    chk("lane_ack", 32'(bus.lane_ack), (m_ack >= 0) ? (32'd1 << m_ack) : 32'd0);
    chk("hit0", 32'(bus.hit0), m_pub_hit[0]);
    chk("hit1", 32'(bus.hit1), m_pub_hit[1]);
    chk("hit2", 32'(bus.hit2), m_pub_hit[2]);
    chk("hit3", 32'(bus.hit3), m_pub_hit[3]);
    chk("miss0", 32'(bus.miss0), m_pub_miss[0]);
    chk("miss1", 32'(bus.miss1), m_pub_miss[1]);
    chk("miss2", 32'(bus.miss2), m_pub_miss[2]);
    chk("miss3", 32'(bus.miss3), m_pub_miss[3]);
    chk("combo", 32'(bus.combo), m_combo);
    chk("max_combo", 32'(bus.max_combo), m_max);
  end

  task automatic cyc();
    @(negedge Clk);
    #2;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      cyc();
      n++;
      done = (evq[0].size() + evq[1].size() + evq[2].size() + evq[3].size() == 0) &&
             (bus.lane_req == 4'b0000);
    end
    chk({name, "_idle_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic frame();
    frame_clk = 1'b1;
    repeat (3) cyc();
    frame_clk = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    int order [$];
    bus.lane_req  = 4'b0000;
    bus.lane_miss = 4'b0000;
    repeat (3) cyc();
    chk("reset_ack", 32'(bus.lane_ack), 32'd0);
    chk("reset_combo", 32'(bus.combo), 32'd0);
    reset = 1'b0;
    cyc();

    // Single hit on lane 2.
    evq[2].push_back(1'b0);
    repeat (2) cyc();
    chk("t1_ack", 32'(bus.lane_ack), 32'h4);
    chk("t1_combo", 32'(bus.combo), 32'd1);
    chk("t1_max", 32'(bus.max_combo), 32'd1);
    wait_idle(10, "t1");
    frame();
    chk("t1_hit2", 32'(bus.hit2), 32'd1);
    chk("t1_hit0", 32'(bus.hit0), 32'd0);
    chk("t1_miss2", 32'(bus.miss2), 32'd0);

    // Four-way contention from rr=0, then a miss on lane 3.
    do_reset();
    for (int k = 0; k < 4; k++) evq[k].push_back(1'b0);
    for (int c = 0; c < 8; c++) begin
      cyc();
      for (int k = 0; k < 4; k++) if (bus.lane_ack[k] === 1'b1) order.push_back(k);
    end
    chk("t2_order_len", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++) chk("t2_order", 32'(order[i]), 32'(i));
    chk("t2_combo", 32'(bus.combo), 32'd4);
    evq[3].push_back(1'b1);
    wait_idle(10, "t2");
    chk("t2_combo_after_miss", 32'(bus.combo), 32'd0);
    chk("t2_max", 32'(bus.max_combo), 32'd4);
    frame();
    chk("t2_hit0", 32'(bus.hit0), 32'd1);
    chk("t2_hit3", 32'(bus.hit3), 32'd1);
    chk("t2_miss3", 32'(bus.miss3), 32'd1);

    // Lane 0 held high: 20 events over 40 cycles, count saturates.
    ack_cnt[0] = 0;
    for (int i = 0; i < 20; i++) evq[0].push_back(1'b0);
    wait_idle(60, "t3");
    chk("t3_acks", 32'(ack_cnt[0]), 32'd20);
    chk("t3_combo", 32'(bus.combo), 32'd20);
    chk("t3_max", 32'(bus.max_combo), 32'd20);
    frame();
    chk("t3_hit0_sat", 32'(bus.hit0), 32'd15);

    // Lane 1 grant coinciding with the frame edge.
    for (int i = 0; i < 3; i++) evq[1].push_back(1'b0);
    wait_idle(20, "t4a");
    evq[1].push_back(1'b0);
    cyc();
    frame_clk = 1'b1;
    cyc();
    chk("t4_edge_ack", 32'(bus.lane_ack), 32'h2);
    chk("t4_hit1_old", 32'(bus.hit1), 32'd3);
    repeat (2) cyc();
    frame_clk = 1'b0;
    wait_idle(10, "t4b");
    frame();
    chk("t4_hit1_new", 32'(bus.hit1), 32'd1);

    // Reset while lane 1 is requesting with five hits accumulated.
    for (int i = 0; i < 5; i++) evq[1].push_back(1'b0);
    wait_idle(20, "t5a");
    evq[1].push_back(1'b0);
    reset = 1'b1;
    cyc();
    chk("t5_ack_in_reset", 32'(bus.lane_ack), 32'd0);
    chk("t5_combo", 32'(bus.combo), 32'd0);
    chk("t5_max", 32'(bus.max_combo), 32'd0);
    chk("t5_hit1", 32'(bus.hit1), 32'd0);
    reset = 1'b0;
    cyc();
    chk("t5_ack_after", 32'(bus.lane_ack), 32'h2);
    chk("t5_combo_after", 32'(bus.combo), 32'd1);
    wait_idle(10, "t5b");
    frame();
    chk("t5_hit1_frame", 32'(bus.hit1), 32'd1);

    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
